dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the RV32I core's load/store port.
- Accepts one request per handshake: address, write enable, write data and funct3 (access size and signedness).
- Performs byte-lane merge on stores and sign/zero extension on loads against an internal word-organised RAM.
- Returns the result after a programmable number of wait states, with an error flag for misaligned, out-of-range or illegal accesses.

Parameters:
- ADDR_WIDTH, 8, log2 of RAM depth in 32-bit words (RAM holds 2^ADDR_WIDTH words).
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; 0 is legal.
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be word aligned.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bytes are used for sb/sh.
- req_funct3  input  3  RV32I funct3 of the load/store.
- rsp_valid  output  1  one-cycle pulse: response valid.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected; qualified by rsp_valid.
- dbg_addr  input  ADDR_WIDTH  debug word index.
- dbg_data  output  32  combinational read of RAM[dbg_addr].

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= IDLE, wait counter <= 0, rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0.
  - RAM contents are not cleared.
  - req_ready is decoded from state, so it reads 1 from the first edge after reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, capture we/addr/wdata/funct3.
  - Go to WAIT with counter=WAIT_CYCLES, or directly to RESP when WAIT_CYCLES==0.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==1, the next edge goes to RESP.
- Commit point is the edge that enters RESP. On that edge:
  - the store is written to RAM;
  - rsp_rdata and rsp_err are registered;
  - rsp_valid is set to 1.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - The next edge clears rsp_valid and returns to IDLE.
  - No back-pressure; the requester must sample during this cycle.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- Requests are ignored while not in IDLE; req_valid may stay asserted.
- Offset and word index:
  - off = req_addr - BASE_ADDR (32-bit, wraps modulo 2^32).
  - Word index = off[ADDR_WIDTH+1:2]; byte lane = off[1:0].
- Loads (little-endian), by funct3:
  - 000 lb: sign-extend the selected byte.
  - 001 lh: sign-extend the selected half.
  - 010 lw: full word.
  - 100 lbu: zero-extend the selected byte.
  - 101 lhu: zero-extend the selected half.
- Stores, by funct3:
  - 000 sb: write req_wdata[7:0] into lane off[1:0].
  - 001 sh: write req_wdata[15:0] into half off[1].
  - 010 sw: write the full word.
  - Unwritten lanes keep their old value.
- Error cases (any one):
  - off >= 4*2^ADDR_WIDTH;
  - halfword access with off[0]!=0;
  - word access with off[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- On error: RAM is unchanged, rsp_err=1, rsp_rdata=0. Latency is unchanged.
- Reset while in WAIT or RESP:
  - Return to IDLE; no response pulse is issued.
  - A store still in WAIT is dropped. A store already past the commit edge remains written.
- Reset and req_valid in the same cycle: reset wins; the request is not accepted.
- dbg_data is purely combinational and unaffected by the FSM.

Test Plan:
- WAIT_CYCLES=1, BASE=0: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> each rsp_valid is 2 edges after acceptance; load rsp_rdata=0xDEADBEEF, rsp_err=0; dbg_addr=4 gives 0xDEADBEEF.
- Byte lanes: sw 0x20 data 0; sb 0x23 data 0x80; sh 0x20 data 0x1234 -> lw 0x20=0x80001234; lb 0x23=0xFFFFFF80; lbu 0x23=0x00000080; lh 0x20=0x00001234.
- Errors: lh 0x21; sw 0x22; lw at 4*2^ADDR_WIDTH (0x400); load funct3=011 -> rsp_err=1, rsp_rdata=0; prior RAM contents unchanged (verified via dbg).
- Latency sweep WAIT_CYCLES=0 and 3 -> rsp_valid after exactly 1 and 4 edges; req_ready low from the accepting edge until after the RESP cycle; held req_valid accepted once per 2 and 5 cycles.
- WAIT_CYCLES=3: sw 0x40 data 0x55 with word 0x40 preloaded 0xAA; reset low in the 2nd WAIT cycle -> no rsp_valid, word stays 0xAA, req_ready=1 after reset.
- BASE_ADDR=0x1000_0000: lw 0x1000_0004 hits word 1; lw 0x0000_0004 -> rsp_err=1 (wrapped offset out of range).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: word-organised RAM with
// byte-lane stores, sign/zero-extended loads, programmable wait states and an error flag.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [31:0]           dbg_data
);
    localparam int              CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   WAIT_LD = CW'(WAIT_CYCLES);
    localparam int              DEPTH   = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      f3_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;
    logic [31:0]     mem_q [DEPTH];

    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [2:0]            cur_f3;
    logic                  commit;
    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic                  acc_err;
    logic [31:0]           rdata_d;
    logic [3:0]            be;
    logic [31:0]           wd_rep;
    logic [31:0]           merged;

    // With zero wait states the access commits on the accepting edge, so it
    // must be decoded from the live request rather than the captured copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_f3    = req_funct3;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
        end
    end

    assign commit = ((state_q == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == CW'(1)));

    assign off     = cur_addr - BASE_ADDR;
    assign idx     = off[ADDR_WIDTH+1:2];
    assign lane    = off[1:0];
    assign word    = mem_q[idx];
    assign ld_byte = word[{lane, 3'b000} +: 8];
    assign ld_half = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        acc_err = |off[31:ADDR_WIDTH+2];
        case (cur_f3[1:0])
            2'b01:   if (lane[0])       acc_err = 1'b1;
            2'b10:   if (lane != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
        if (cur_we && cur_f3[2])            acc_err = 1'b1;
        if (!cur_we && cur_f3 == 3'b110)    acc_err = 1'b1;
    end

    always_comb begin
        rdata_d = 32'h0;
        if (!cur_we && !acc_err) begin
            case (cur_f3)
                3'b000:  rdata_d = {{24{ld_byte[7]}}, ld_byte};
                3'b001:  rdata_d = {{16{ld_half[15]}}, ld_half};
                3'b010:  rdata_d = word;
                3'b100:  rdata_d = {24'h0, ld_byte};
                3'b101:  rdata_d = {16'h0, ld_half};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_comb begin
        be     = 4'b0000;
        wd_rep = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{cur_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wd_rep[8*i +: 8] : word[8*i +: 8];
        end
    end

    // RAM has no reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (reset && commit && cur_we && !acc_err) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LD;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata_d;
                rsp_err_q   <= acc_err;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_data  = mem_q[dbg_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances covering wait-state and
// base-address variants, checked against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int N = 4;

    function automatic int wc(input int g);
        case (g)
            1:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] ba(input int g);
        return (g == 3) ? 32'h1000_0000 : 32'h0000_0000;
    endfunction

    typedef struct {
        int          g;
        logic [31:0] rd;
        bit          err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    bit   started = 0;
    exp_t sbq[$];
    logic [7:0] rm [N][1024];

    logic        rst_n     [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [2:0]  req_f3    [N];
    logic        rsp_valid [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];
    logic [7:0]  dbg_addr  [N];
    logic [31:0] dbg_data  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH (8),
            .WAIT_CYCLES(wc(g)),
            .BASE_ADDR  (ba(g))
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_funct3(req_f3[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .dbg_addr  (dbg_addr[g]),
            .dbg_data  (dbg_data[g])
        );
    end

    // Reference: byte-addressed little-endian memory; access size from funct3.
    function automatic void model(input int g, input bit we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output logic [31:0] rd, output bit err);
        logic [31:0] off;
        int          sz;
        logic [31:0] v;
        off = a - ba(g);
        sz  = 1 << f3[1:0];
        err = (off >= 32'h400) || (f3[1:0] == 2'b11) || (we && f3[2]) ||
              (!we && f3 == 3'b110) || ((off % sz) != 0);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) rm[g][int'(off) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v = v | ({24'h0, rm[g][int'(off) + i]} << (8 * i));
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end
        end
    endfunction

    function automatic logic [31:0] mword(input int g, input int w);
        return {rm[g][4*w+3], rm[g][4*w+2], rm[g][4*w+1], rm[g][4*w]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            for (int g = 0; g < N; g++) begin
                if (rsp_valid[g] !== 1'b0) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp dut%0d rdata=%h err=%b, no response was due",
                                 g, rsp_rdata[g], rsp_err[g]);
                    end else begin
                        e = sbq.pop_front();
                        if (e.g != g || rsp_rdata[g] !== e.rd || rsp_err[g] !== e.err || cyc != e.due) begin
                            errors++;
                            $display("FAIL rsp got dut%0d rdata=%h err=%b edge=%0d, want dut%0d rdata=%h err=%b edge=%0d",
                                     g, rsp_rdata[g], rsp_err[g], cyc, e.g, e.rd, e.err, e.due);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_dbg(input int g, input int w);
        @(negedge clk);
        dbg_addr[g] = w[7:0];
        #1;
        chk($sformatf("dbg dut%0d word%0d", g, w), dbg_data[g], mword(g, w));
    endtask

    task automatic wait_rsp(input int g);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(negedge clk);
            if (sbq.size() != 0) chk($sformatf("ready_busy dut%0d", g), {31'h0, req_ready[g]}, 32'h0);
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut%0d pending=%0d want=0", g, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic push_exp(input int g);
        exp_t        e;
        logic [31:0] rd;
        bit          er;
        model(g, req_we[g], req_addr[g], req_wdata[g], req_f3[g], rd, er);
        e.g   = g;
        e.rd  = rd;
        e.err = er;
        e.due = cyc + 1 + wc(g);
        sbq.push_back(e);
    endtask

    task automatic issue(input int g, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        @(negedge clk);
        chk($sformatf("ready_idle dut%0d", g), {31'h0, req_ready[g]}, 32'h1);
        req_valid[g] = 1'b1;
        req_we[g]    = we;
        req_addr[g]  = a;
        req_wdata[g] = wd;
        req_f3[g]    = f3;
        @(posedge clk);
        push_exp(g);
        #1 req_valid[g] = 1'b0;
        wait_rsp(g);
    endtask

    // Held request: accepted once every wc+2 edges.
    task automatic hold3(input int g, input logic [31:0] a);
        @(negedge clk);
        req_valid[g] = 1'b1;
        req_we[g]    = 1'b0;
        req_addr[g]  = a;
        req_f3[g]    = 3'b010;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) @(posedge clk);
            else repeat (wc(g) + 2) @(posedge clk);
            push_exp(g);
        end
        #1 req_valid[g] = 1'b0;
        wait_rsp(g);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < N; g++) begin
            rst_n[g] = 1'b0; req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0;
            req_wdata[g] = '0; req_f3[g] = '0; dbg_addr[g] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
        started = 1;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_ready dut%0d", g), {31'h0, req_ready[g]}, 32'h1);
            chk($sformatf("rst_valid dut%0d", g), {31'h0, rsp_valid[g]}, 32'h0);
            chk($sformatf("rst_err dut%0d", g), {31'h0, rsp_err[g]}, 32'h0);
            chk($sformatf("rst_rdata dut%0d", g), rsp_rdata[g], 32'h0);
        end

        for (int g = 0; g < N; g++)
            for (int w = 0; w < 256; w++) issue(g, 1'b1, ba(g) + 32'(4 * w), $urandom, 3'b010);

        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
        issue(0, 1'b0, 32'h10, 32'h0, 3'b010);
        chk_dbg(0, 4);
        chk("plan_dbg4", dbg_data[0], 32'hDEAD_BEEF);

        issue(0, 1'b1, 32'h20, 32'h0, 3'b010);
        issue(0, 1'b1, 32'h23, 32'h80, 3'b000);
        issue(0, 1'b1, 32'h20, 32'h1234, 3'b001);
        issue(0, 1'b0, 32'h20, 32'h0, 3'b010);
        issue(0, 1'b0, 32'h23, 32'h0, 3'b000);
        issue(0, 1'b0, 32'h23, 32'h0, 3'b100);
        issue(0, 1'b0, 32'h20, 32'h0, 3'b001);
        chk_dbg(0, 8);
        chk("plan_word20", dbg_data[0], 32'h8000_1234);

        issue(0, 1'b0, 32'h21, 32'h0, 3'b001);
        issue(0, 1'b1, 32'h22, 32'hFFFF_FFFF, 3'b010);
        issue(0, 1'b0, 32'h400, 32'h0, 3'b010);
        issue(0, 1'b0, 32'h20, 32'h0, 3'b011);
        issue(0, 1'b1, 32'h21, 32'hFFFF_FFFF, 3'b001);
        chk_dbg(0, 8);
        chk("err_word20_kept", dbg_data[0], 32'h8000_1234);

        hold3(1, 32'h10);
        hold3(2, 32'h10);
        hold3(0, 32'h10);

        issue(2, 1'b1, 32'h40, 32'hAA, 3'b010);
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h40;
        req_wdata[2] = 32'h55; req_f3[2] = 3'b010;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(posedge clk);
        #1 rst_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_ready", {31'h0, req_ready[2]}, 32'h1);
        chk_dbg(2, 16);
        chk("rst_mid_word40", dbg_data[2], 32'h0000_00AA);

        issue(3, 1'b0, 32'h1000_0004, 32'h0, 3'b010);
        issue(3, 1'b0, 32'h0000_0004, 32'h0, 3'b010);
        issue(3, 1'b1, 32'h1000_0006, 32'hBEEF, 3'b001);
        issue(3, 1'b0, 32'h1000_0007, 32'h0, 3'b000);
        issue(3, 1'b0, 32'h0FFF_FFFF, 32'h0, 3'b100);

        for (int g = 0; g < N; g++) begin
            for (int k = 0; k < 150; k++) begin
                int          r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                if (r == 0)      a = $urandom;
                else if (r == 1) a = ba(g) + 32'h400 + 32'($urandom_range(0, 63));
                else             a = ba(g) + 32'($urandom_range(0, 1023));
                issue(g, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
                if (k % 30 == 0) chk_dbg(g, $urandom_range(0, 255));
            end
        end

        for (int g = 0; g < N; g++)
            for (int w = 0; w < 256; w++) chk_dbg(g, w);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
